// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the mcs6530 bus master.
package mcs6530_pkg;

  // Request opcodes as carried on req_op.
  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpWrite = 2'b01,
    OpRmw   = 2'b10,
    OpRsvd  = 2'b11
  } bus_op_t;

  // Bus master sequencing states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StResp = 2'b11
  } bm_state_t;

  // Value returned when nothing drives the data bus.
  localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

  // Insert the masked bits of ins_data into old_data.
  function automatic logic [7:0] rmw_merge(input logic [7:0] old_data,
                                           input logic [7:0] ins_data,
                                           input logic [7:0] mask);
    return (old_data & ~mask) | (ins_data & mask);
  endfunction

endpackage

// File: rtl/mcs6530_bus_master.sv
// 6502-side bus initiator for the mcs6530 RRIOT: one outstanding read, write
// or read-modify-write request at a time, driven on phi2 cycles.
module mcs6530_bus_master
  import mcs6530_pkg::*;
#(
  parameter int unsigned RD_LAT = 1  // 1..4
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [9:0] req_addr,
  input  logic       req_rs0,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_mask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [9:0] A,
  output logic       RS0,
  output logic       we_n,
  output logic [7:0] DI,
  input  logic [7:0] DO,
  input  logic       OE,
  output logic       busy
);

  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  bm_state_t  state_q, state_d;
  bus_op_t    op_q;
  logic [9:0] addr_q;
  logic       rs0_q;
  logic [7:0] wdata_q;
  logic [7:0] mask_q;
  logic [1:0] cnt_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       accept;

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (bus_op_t'(req_op))
            OpRead, OpRmw: state_d = StRd;
            OpWrite:       state_d = StWr;
            OpRsvd:        state_d = StResp;
          endcase
        end
      end
      StRd: begin
        // An RMW only proceeds to the write phase when the read saw a driven bus.
        if (cnt_q == 2'd0) begin
          state_d = (op_q == OpRmw && OE) ? StWr : StResp;
        end
      end
      StWr:   state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
    endcase
  end

  // Request latch, read-latency counter and response capture.
  always_ff @(posedge phi2) begin
    if (rst) begin
      op_q    <= OpRead;
      addr_q  <= 10'd0;
      rs0_q   <= 1'b0;
      wdata_q <= 8'h00;
      mask_q  <= 8'h00;
      cnt_q   <= 2'd0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= bus_op_t'(req_op);
      addr_q  <= req_addr;
      rs0_q   <= req_rs0;
      wdata_q <= req_wdata;
      mask_q  <= req_mask;
      cnt_q   <= CntInit;
      rdata_q <= 8'h00;
      err_q   <= (bus_op_t'(req_op) == OpRsvd);
    end else if (state_q == StRd) begin
      if (cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end else begin
        rdata_q <= OE ? DO : OPEN_BUS_DATA;
        err_q   <= !OE;
      end
    end else if (state_q == StWr) begin
      // rdata_q keeps the pre-modify value for RMW and 0x00 for plain writes.
      err_q <= 1'b0;
    end
  end

  // Bus and handshake outputs.
  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
    we_n      = (state_q != StWr) || rst;
    DI        = 8'h00;
    if (state_q == StWr && !rst) begin
      DI = (op_q == OpRmw) ? rmw_merge(rdata_q, wdata_q, mask_q) : wdata_q;
    end
  end

  assign A         = addr_q;
  assign RS0       = rs0_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Bench for mcs6530_bus_master: two instances (read latency 1 and 4) each
// talking to a simple byte-memory device model.
module tb_mcs6530_bus_master;

  localparam int unsigned Lat0 = 1;
  localparam int unsigned Lat1 = 4;

  logic       phi2;
  logic       rst       [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic [1:0] req_op    [2];
  logic [9:0] req_addr  [2];
  logic       req_rs0   [2];
  logic [7:0] req_wdata [2];
  logic [7:0] req_mask  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic [9:0] A         [2];
  logic       RS0       [2];
  logic       we_n      [2];
  logic [7:0] DI        [2];
  logic [7:0] DO        [2];
  logic       OE        [2];
  logic       busy      [2];
  logic       oe_low    [2];

  logic [7:0] dev_mem   [2][2048];
  logic [7:0] model_mem [2][2048];
  logic       mem_init;
  logic [7:0] seed;

  int checks;
  int failures;

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  mcs6530_bus_master #(.RD_LAT(Lat0)) u_dut0 (
    .phi2(phi2), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_addr(req_addr[0]), .req_rs0(req_rs0[0]),
    .req_wdata(req_wdata[0]), .req_mask(req_mask[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .A(A[0]), .RS0(RS0[0]), .we_n(we_n[0]), .DI(DI[0]), .DO(DO[0]), .OE(OE[0]),
    .busy(busy[0])
  );

  mcs6530_bus_master #(.RD_LAT(Lat1)) u_dut1 (
    .phi2(phi2), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_addr(req_addr[1]), .req_rs0(req_rs0[1]),
    .req_wdata(req_wdata[1]), .req_mask(req_mask[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .A(A[1]), .RS0(RS0[1]), .we_n(we_n[1]), .DI(DI[1]), .DO(DO[1]), .OE(OE[1]),
    .busy(busy[1])
  );

  function automatic logic [7:0] init_byte(input int d, input int idx);
    logic [10:0] i;
    i = 11'(idx);
    return i[7:0] ^ {i[10:8], 5'b0} ^ seed ^ (d == 1 ? 8'h5B : 8'h00);
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(Lat0) : int'(Lat1);
  endfunction

  // Device model: asynchronous read, write committed on the edge ending a we_n-low cycle.
  assign DO[0] = dev_mem[0][{RS0[0], A[0]}];
  assign DO[1] = dev_mem[1][{RS0[1], A[1]}];
  assign OE[0] = !oe_low[0];
  assign OE[1] = !oe_low[1];

  // Device memory contents: bulk preset, then bus writes.
  always @(posedge phi2) begin
    if (mem_init) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 2048; i++) dev_mem[d][i] <= init_byte(d, i);
      end
    end else begin
      if (!we_n[0]) dev_mem[0][{RS0[0], A[0]}] <= DI[0];
      if (!we_n[1]) dev_mem[1][{RS0[1], A[1]}] <= DI[1];
    end
  end

  // Drive one request and observe it until the response handshake completes.
  task automatic run_op(input int d, input logic [1:0] op, input logic [9:0] addr,
                        input logic rs0, input logic [7:0] wdata, input logic [7:0] mask,
                        input bit oe_all_low, input bit oe_window, input int stall,
                        output logic [7:0] rdata, output logic err, output int lat,
                        output int we_cnt, output logic [7:0] we_di, output bit a_held,
                        output bit stall_ok, output bit ready_after, output bit timeout);
    int n;
    int k;
    we_cnt = 0; we_di = 8'h00; a_held = 1'b1; stall_ok = 1'b1; timeout = 1'b0;
    rdata = 8'h00; err = 1'b0; lat = -1; ready_after = 1'b0;
    @(negedge phi2);
    req_op[d] = op; req_addr[d] = addr; req_rs0[d] = rs0;
    req_wdata[d] = wdata; req_mask[d] = mask; req_valid[d] = 1'b1;
    oe_low[d] = oe_all_low;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge phi2);
      n++;
    end
    if (!req_ready[d]) begin
      timeout = 1'b1;
      req_valid[d] = 1'b0;
      return;
    end
    @(negedge phi2);
    req_valid[d] = 1'b0;
    k = 0;
    forever begin
      if (oe_window) oe_low[d] = (k != lat_of(d) - 1);
      if (A[d] !== addr || RS0[d] !== rs0) a_held = 1'b0;
      if (!we_n[d]) begin
        we_cnt++;
        we_di = DI[d];
      end
      if (rsp_valid[d] === 1'b1 || k >= 50) break;
      @(negedge phi2);
      k++;
    end
    if (rsp_valid[d] !== 1'b1) begin
      timeout = 1'b1;
      oe_low[d] = 1'b0;
      return;
    end
    lat = k; rdata = rsp_rdata[d]; err = rsp_err[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge phi2);
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rdata || rsp_err[d] !== err ||
          req_ready[d] !== 1'b0 || we_n[d] !== 1'b1 || A[d] !== addr) stall_ok = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    @(negedge phi2);
    rsp_ready[d] = 1'b0;
    oe_low[d] = 1'b0;
    ready_after = req_ready[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; oe_low[d] = 1'b0;
      req_op[d] = 2'b00; req_addr[d] = 10'd0; req_rs0[d] = 1'b0;
      req_wdata[d] = 8'h00; req_mask[d] = 8'h00;
    end
    seed = 8'($urandom);
    mem_init = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2048; i++) model_mem[d][i] = init_byte(d, i);
    repeat (3) @(negedge phi2);
    mem_init = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || busy[d] !== 1'b0 || rsp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctrl[%0d]: ready=%b busy=%b valid=%b, required 0 0 0", d,
                 req_ready[d], busy[d], rsp_valid[d]);
      end
      checks++;
      if (A[d] !== 10'd0 || RS0[d] !== 1'b0 || we_n[d] !== 1'b1 || DI[d] !== 8'h00) begin
        failures++;
        $display("FAIL reset_bus[%0d]: A=%h RS0=%b we_n=%b DI=%h, required 000 0 1 00", d,
                 A[d], RS0[d], we_n[d], DI[d]);
      end
      checks++;
      if (rsp_rdata[d] !== 8'h00 || rsp_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_rsp[%0d]: rdata=%h err=%b, required 00 0", d, rsp_rdata[d],
                 rsp_err[d]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge phi2);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_reset[%0d]: got %b required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    run_op(0, 2'b01, 10'h07C, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    model_mem[0][{1'b1, 10'h07C}] = 8'h5A;
    checks++;
    if (to || wc != 1 || wdi !== 8'h5A || lat != 1) begin
      failures++;
      $display("FAIL write_bus: to=%0b we_cycles=%0d DI=%h lat=%0d, required 0 1 5a 1",
               to, wc, wdi, lat);
    end
    checks++;
    if (rd !== 8'h00 || er !== 1'b0 || !ah || !ra) begin
      failures++;
      $display("FAIL write_rsp: rdata=%h err=%b a_held=%0b ready=%0b, required 00 0 1 1",
               rd, er, ah, ra);
    end
    run_op(0, 2'b00, 10'h07C, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== 8'h5A || er !== 1'b0 || lat != 1 || wc != 0) begin
      failures++;
      $display("FAIL read_back: rdata=%h err=%b lat=%0d we_cycles=%0d, required 5a 0 1 0",
               rd, er, lat, wc);
    end
  endtask

  task automatic test_rmw();
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    run_op(0, 2'b01, 10'h123, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    run_op(0, 2'b10, 10'h123, 1'b0, 8'h0F, 8'h3C, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    model_mem[0][{1'b0, 10'h123}] = 8'hCC;
    checks++;
    if (to || rd !== 8'hF0 || er !== 1'b0 || wc != 1 || wdi !== 8'hCC || lat != 2) begin
      failures++;
      $display("FAIL rmw: rdata=%h err=%b we_cycles=%0d DI=%h lat=%0d, required f0 0 1 cc 2",
               rd, er, wc, wdi, lat);
    end
    run_op(0, 2'b00, 10'h123, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== 8'hCC || er !== 1'b0) begin
      failures++;
      $display("FAIL rmw_readback: rdata=%h err=%b, required cc 0", rd, er);
    end
  endtask

  task automatic test_open_bus();
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    run_op(0, 2'b00, 10'h07C, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== 8'hFF || er !== 1'b1) begin
      failures++;
      $display("FAIL open_bus_read: rdata=%h err=%b, required ff 1", rd, er);
    end
    run_op(0, 2'b10, 10'h07C, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== 8'hFF || er !== 1'b1 || wc != 0 || lat != 1) begin
      failures++;
      $display("FAIL open_bus_rmw: rdata=%h err=%b we_cycles=%0d lat=%0d, required ff 1 0 1",
               rd, er, wc, lat);
    end
  endtask

  task automatic test_lat4_stall();
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    logic [7:0] exp;
    exp = model_mem[1][{1'b1, 10'h2A5}];
    // OE is only high in the cycle that ends on edge N+4, so any other sample point errs.
    run_op(1, 2'b00, 10'h2A5, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 10,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== exp || er !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL lat4_read: rdata=%h err=%b lat=%0d, required %h 0 4", rd, er, lat, exp);
    end
    checks++;
    if (!ah || !so || !ra) begin
      failures++;
      $display("FAIL lat4_stall: a_held=%0b stall_stable=%0b ready_after=%0b, required 1 1 1",
               ah, so, ra);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    run_op(0, 2'b01, 10'h055, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    model_mem[0][{1'b0, 10'h055}] = 8'h11;
    @(negedge phi2);
    req_op[0] = 2'b01; req_addr[0] = 10'h055; req_rs0[0] = 1'b0; req_wdata[0] = 8'hAA;
    req_valid[0] = 1'b1;
    @(negedge phi2);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    checks++;
    if (we_n[0] !== 1'b1 || DI[0] !== 8'h00) begin
      failures++;
      $display("FAIL rst_suppress: we_n=%b DI=%h, required 1 00", we_n[0], DI[0]);
    end
    @(negedge phi2);
    checks++;
    if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || A[0] !== 10'd0 || req_ready[0] !== 1'b0 ||
        rsp_rdata[0] !== 8'h00 || rsp_err[0] !== 1'b0 || we_n[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_state: busy=%b valid=%b A=%h ready=%b rdata=%h err=%b we_n=%b",
               busy[0], rsp_valid[0], A[0], req_ready[0], rsp_rdata[0], rsp_err[0], we_n[0]);
    end
    rst[0] = 1'b0;
    run_op(0, 2'b00, 10'h055, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== 8'h11 || er !== 1'b0) begin
      failures++;
      $display("FAIL rst_mem_kept: rdata=%h err=%b, required 11 0", rd, er);
    end
  endtask

  task automatic test_reserved();
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    run_op(1, 2'b11, 10'h3FF, 1'b1, 8'h77, 8'hFF, 1'b0, 1'b0, 0,
           rd, er, lat, wc, wdi, ah, so, ra, to);
    checks++;
    if (to || rd !== 8'h00 || er !== 1'b1 || wc != 0 || lat != 0) begin
      failures++;
      $display("FAIL reserved_op: rdata=%h err=%b we_cycles=%0d lat=%0d, required 00 1 0 0",
               rd, er, wc, lat);
    end
  endtask

  // Random traffic against a transaction-level memory model.
  task automatic test_random(input int d, input int nops);
    logic [7:0] rd; logic er; int lat; int wc; logic [7:0] wdi;
    bit ah; bit so; bit ra; bit to;
    logic [1:0] op; logic [9:0] addr; logic rs0; logic [7:0] wd; logic [7:0] mk;
    bit ol; logic [10:0] idx;
    logic [7:0] e_rd; logic e_er; int e_lat; int e_wc; logic [7:0] e_di;
    for (int t = 0; t < nops; t++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11 && $urandom_range(0, 2) != 0) op = 2'b00;
      addr = 10'($urandom_range(0, 7)) + 10'h200;
      rs0 = 1'($urandom);
      wd = 8'($urandom); mk = 8'($urandom);
      ol = ($urandom_range(0, 7) == 0);
      idx = {rs0, addr};
      e_wc = 0; e_di = 8'h00;
      case (op)
        2'b00: begin
          e_rd = ol ? 8'hFF : model_mem[d][idx]; e_er = ol; e_lat = lat_of(d);
        end
        2'b01: begin
          e_rd = 8'h00; e_er = 1'b0; e_lat = 1; e_wc = 1; e_di = wd;
          model_mem[d][idx] = wd;
        end
        2'b10: begin
          if (ol) begin
            e_rd = 8'hFF; e_er = 1'b1; e_lat = lat_of(d);
          end else begin
            e_rd = model_mem[d][idx]; e_er = 1'b0; e_lat = lat_of(d) + 1; e_wc = 1;
            e_di = (e_rd & ~mk) | (wd & mk);
            model_mem[d][idx] = e_di;
          end
        end
        default: begin
          e_rd = 8'h00; e_er = 1'b1; e_lat = 0;
        end
      endcase
      run_op(d, op, addr, rs0, wd, mk, ol, 1'b0, 0, rd, er, lat, wc, wdi, ah, so, ra, to);
      checks++;
      if (to || rd !== e_rd || er !== e_er || lat != e_lat || wc != e_wc ||
          wdi !== e_di || !ah || !ra) begin
        failures++;
        $display("FAIL rand[%0d.%0d] op=%0d: rdata=%h err=%b lat=%0d we=%0d DI=%h held=%0b rdy=%0b to=%0b, required %h %b %0d %0d %h 1 1 0",
                 d, t, op, rd, er, lat, wc, wdi, ah, ra, to, e_rd, e_er, e_lat, e_wc, e_di);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_rmw();
    test_open_bus();
    test_lat4_stall();
    test_reset_mid_write();
    test_reserved();
    test_random(0, 60);
    test_random(1, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
